// File: rtl/branch_target_unit.sv
// Branch target adder plus direct-mapped BTB with 2-bit counters, redirect and statistics.
// Latency: f_* and r_target combinational; redirect/redirect_pc/counters one cycle after r_valid.
// Backpressure: none, one resolved branch accepted every cycle.
module branch_target_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int SHIFT = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] f_pc,
    output logic             f_hit,
    output logic             f_pred_taken,
    output logic [WIDTH-1:0] f_next_pc,
    input  logic             r_valid,
    input  logic [WIDTH-1:0] r_pc,
    input  logic [WIDTH-1:0] r_npc,
    input  logic [WIDTH-1:0] r_offset,
    input  logic             r_taken,
    input  logic             r_pred_taken,
    input  logic [WIDTH-1:0] r_pred_target,
    output logic [WIDTH-1:0] r_target,
    output logic             redirect,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int IDX   = $clog2(DEPTH);
    localparam int TAG_W = WIDTH - IDX - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] target;
        logic [1:0]       ctr;
    } entry_t;

    entry_t btb [DEPTH];

    logic [IDX-1:0]   f_idx, r_idx;
    logic [TAG_W-1:0] f_tag, r_tag;
    entry_t           f_ent, r_ent;
    logic             r_hit, mis;

    assign f_idx = f_pc[IDX+1:2];
    assign f_tag = f_pc[WIDTH-1:IDX+2];
    assign r_idx = r_pc[IDX+1:2];
    assign r_tag = r_pc[WIDTH-1:IDX+2];
    assign f_ent = btb[f_idx];
    assign r_ent = btb[r_idx];

    assign f_hit        = f_ent.valid && (f_ent.tag == f_tag);
    assign f_pred_taken = f_hit && f_ent.ctr[1];
    assign f_next_pc    = f_pred_taken ? f_ent.target : f_pc + WIDTH'(4);

    // Carry out of the adder and shifted-out offset bits are dropped by design.
    assign r_target = r_npc + (r_offset << SHIFT);
    assign r_hit    = r_ent.valid && (r_ent.tag == r_tag);
    assign mis      = r_valid && ((r_taken != r_pred_taken) ||
                                  (r_taken && (r_pred_target != r_target)));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                btb[i] <= '0;
            end
            redirect    <= 1'b0;
            redirect_pc <= '0;
            br_count    <= '0;
            miss_count  <= '0;
        end else begin
            redirect <= mis;
            if (mis) begin
                redirect_pc <= r_taken ? r_target : r_npc;
            end
            if (r_valid) begin
                if (br_count != '1) begin
                    br_count <= br_count + CNT_W'(1);
                end
                if (mis && (miss_count != '1)) begin
                    miss_count <= miss_count + CNT_W'(1);
                end
                if (r_hit) begin
                    if (r_taken) begin
                        btb[r_idx].target <= r_target;
                        if (r_ent.ctr != 2'b11) begin
                            btb[r_idx].ctr <= r_ent.ctr + 2'b01;
                        end
                    end else if (r_ent.ctr != 2'b00) begin
                        btb[r_idx].ctr <= r_ent.ctr - 2'b01;
                    end
                end else if (r_taken) begin
                    // Cold miss or alias: allocate weakly taken.
                    btb[r_idx] <= '{valid: 1'b1, tag: r_tag, target: r_target, ctr: 2'b10};
                end
            end
        end
    end
endmodule
